// File: rtl/cic_decim_ctrl_if.sv
// Handshake and strobe bundle between the CIC decimation
// controller and its datapath / upstream / downstream neighbours.
//  master: drives Data_RDY, out_ack, clr_overrun; observes the rest
//  slave : the controller; drives strobes, sample_rdy, dec_count, overrun
interface cic_decim_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             Data_RDY;
  logic             out_ack;
  logic             clr_overrun;
  logic             load_in;
  logic             pulse_integ;
  logic             pulse_comb;
  logic             load_result;
  logic             sample_rdy;
  logic [CNT_W-1:0] dec_count;
  logic             overrun;

  modport master (
    output Data_RDY, out_ack, clr_overrun,
    input  load_in, pulse_integ, pulse_comb,
    input  load_result, sample_rdy,
    input  dec_count, overrun
  );

  modport slave (
    input  Data_RDY, out_ack, clr_overrun,
    output load_in, pulse_integ, pulse_comb,
    output load_result, sample_rdy,
    output dec_count, overrun
  );
endinterface

// File: rtl/cic_decim_ctrl.sv
// Control FSM for the CIC decimation path: integrator strobe per input,
// comb/result strobes every DEC_RATE-th input, then a valid/ack output.
//  CLOCK, RESET (sync, active high)
//  bus (slave): Data_RDY, out_ack, clr_overrun in;
//               load_in, pulse_integ, pulse_comb, load_result,
//               sample_rdy, dec_count, overrun out
module cic_decim_ctrl #(
  parameter int DEC_RATE = 8,
  parameter int CNT_W    = 3
) (
  input  logic                CLOCK,
  input  logic                RESET,
  cic_decim_ctrl_if.slave     bus
);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] LOAD_IN      = 3'd1;
  localparam logic [2:0] INTEG_SETTLE = 3'd2;
  localparam logic [2:0] COMB1        = 3'd3;
  localparam logic [2:0] COMB2        = 3'd4;
  localparam logic [2:0] SEND         = 3'd5;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEC_RATE - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             ovr;
  logic             drop;
  logic             cnt_last;

  // Samples arriving outside IDLE are lost, including in
  // illegal encodings that are on their way back to IDLE.
  assign drop     = bus.Data_RDY && (state != IDLE);
  assign cnt_last = (cnt == LAST);

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:         state_nxt = bus.Data_RDY ? LOAD_IN : IDLE;
      LOAD_IN:      state_nxt = INTEG_SETTLE;
      INTEG_SETTLE: state_nxt = cnt_last ? COMB1 : IDLE;
      COMB1:        state_nxt = COMB2;
      COMB2:        state_nxt = SEND;
      SEND:         state_nxt = bus.out_ack ? IDLE : SEND;
      default:      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      ovr   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == INTEG_SETTLE)
        cnt <= cnt_last ? '0 : cnt + ONE;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)
        ovr <= 1'b1;
      else if (bus.clr_overrun)
        ovr <= 1'b0;
    end
  end

  always_comb begin
    bus.load_in     = 1'b0;
    bus.pulse_integ = 1'b0;
    bus.pulse_comb  = 1'b0;
    bus.load_result = 1'b0;
    bus.sample_rdy  = 1'b0;
    case (state)
      LOAD_IN: begin
        bus.load_in     = 1'b1;
        bus.pulse_integ = 1'b1;
      end
      COMB1: begin
        bus.pulse_comb  = 1'b1;
        bus.load_result = 1'b1;
      end
      SEND:    bus.sample_rdy = 1'b1;
      default: ;
    endcase
  end

  assign bus.dec_count = cnt;
  assign bus.overrun   = ovr;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl with DEC_RATE=4.
// Strobe vector order: {load_in, pulse_integ, pulse_comb, load_result, sample_rdy}
module tb_cic_decim_ctrl;

  localparam int R = 4;
  localparam int W = 2;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;

  cic_decim_ctrl_if #(.CNT_W(W)) bus ();

  cic_decim_ctrl #(
    .DEC_RATE (R),
    .CNT_W    (W)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int outs();
    return {27'd0, bus.load_in, bus.pulse_integ, bus.pulse_comb,
            bus.load_result, bus.sample_rdy};
  endfunction

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge CLOCK);
    #1;
  endtask

  // Accept one non-final sample from IDLE; ends 4 cycles later in IDLE.
  task automatic feed(input int exp_cnt, input string tag);
    bus.Data_RDY = 1'b1;
    cyc();
    bus.Data_RDY = 1'b0;
    check({tag, " load"}, outs(), 5'b11000);
    cyc();
    check({tag, " settle"}, outs(), 0);
    cyc();
    check({tag, " idle"}, outs(), 0);
    check({tag, " cnt"}, int'(bus.dec_count), exp_cnt);
    cyc();
  endtask

  // Final sample of a frame; returns in cycle k+5 with sample_rdy high.
  task automatic final_to_send(input string tag);
    bus.Data_RDY = 1'b1;
    cyc();
    bus.Data_RDY = 1'b0;
    check({tag, " k+1"}, outs(), 5'b11000);
    cyc();
    check({tag, " k+2"}, outs(), 0);
    check({tag, " k+2 cnt"}, int'(bus.dec_count), R - 1);
    cyc();
    check({tag, " k+3"}, outs(), 5'b00110);
    check({tag, " k+3 cnt"}, int'(bus.dec_count), 0);
    cyc();
    check({tag, " k+4"}, outs(), 0);
    cyc();
    check({tag, " k+5"}, outs(), 5'b00001);
  endtask

  task automatic frame_to_send(input string tag);
    feed(1, {tag, " s1"});
    feed(2, {tag, " s2"});
    feed(3, {tag, " s3"});
    final_to_send({tag, " s4"});
  endtask

  initial begin
    bus.Data_RDY    = 1'b0;
    bus.out_ack     = 1'b0;
    bus.clr_overrun = 1'b0;

    // 1: reset then idle
    RESET = 1'b1;
    cyc();
    cyc();
    RESET = 1'b0;
    check("rst outs", outs(), 0);
    check("rst cnt", int'(bus.dec_count), 0);
    check("rst ovr", int'(bus.overrun), 0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle outs", outs(), 0);
      check("idle cnt", int'(bus.dec_count), 0);
    end

    // 2: three sub-frame samples
    feed(1, "sub1");
    feed(2, "sub2");
    feed(3, "sub3");

    // 3: final sample with immediate ack
    final_to_send("full");
    bus.out_ack = 1'b1;
    cyc();
    bus.out_ack = 1'b0;
    check("full k+6 idle", outs(), 0);
    check("full k+6 cnt", int'(bus.dec_count), 0);

    // 4: ack in IDLE ignored, then delayed ack
    bus.out_ack = 1'b1;
    cyc();
    bus.out_ack = 1'b0;
    check("idle ack outs", outs(), 0);
    check("idle ack cnt", int'(bus.dec_count), 0);
    frame_to_send("dly");
    for (int i = 0; i < 7; i++) begin
      cyc();
      check("dly hold", outs(), 5'b00001);
    end
    bus.out_ack = 1'b1;
    cyc();
    bus.out_ack = 1'b0;
    check("dly drop", outs(), 0);

    // 5: overrun
    bus.Data_RDY = 1'b1;
    cyc();
    check("ovr load", outs(), 5'b11000);
    check("ovr pre", int'(bus.overrun), 0);
    cyc();
    bus.Data_RDY = 1'b0;
    check("ovr set", int'(bus.overrun), 1);
    check("ovr settle outs", outs(), 0);
    check("ovr settle cnt", int'(bus.dec_count), 0);
    cyc();
    check("ovr cnt once", int'(bus.dec_count), 1);
    check("ovr sticky", int'(bus.overrun), 1);
    bus.clr_overrun = 1'b1;
    cyc();
    bus.clr_overrun = 1'b0;
    check("ovr clr", int'(bus.overrun), 0);
    feed(2, "ovr s2");
    feed(3, "ovr s3");
    final_to_send("ovr s4");
    bus.Data_RDY = 1'b1;
    cyc();
    bus.Data_RDY = 1'b0;
    check("send drop outs", outs(), 5'b00001);
    check("send drop cnt", int'(bus.dec_count), 0);
    check("send drop ovr", int'(bus.overrun), 1);
    cyc();
    check("send ovr sticky", int'(bus.overrun), 1);
    bus.Data_RDY    = 1'b1;
    bus.clr_overrun = 1'b1;
    cyc();
    bus.Data_RDY    = 1'b0;
    bus.clr_overrun = 1'b0;
    check("set beats clr", int'(bus.overrun), 1);
    check("set beats clr outs", outs(), 5'b00001);
    bus.out_ack = 1'b1;
    cyc();
    bus.out_ack = 1'b0;
    check("ovr ack idle", outs(), 0);
    bus.clr_overrun = 1'b1;
    cyc();
    bus.clr_overrun = 1'b0;
    check("ovr clr2", int'(bus.overrun), 0);

    // 6: reset in SEND, then in INTEG_SETTLE with dec_count=2
    frame_to_send("rs");
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    check("rst send outs", outs(), 0);
    check("rst send cnt", int'(bus.dec_count), 0);
    feed(1, "ri s1");
    feed(2, "ri s2");
    bus.Data_RDY = 1'b1;
    cyc();
    bus.Data_RDY = 1'b0;
    check("ri load", outs(), 5'b11000);
    cyc();
    check("ri settle cnt", int'(bus.dec_count), 2);
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    check("rst settle outs", outs(), 0);
    check("rst settle cnt", int'(bus.dec_count), 0);
    cyc();
    check("rst settle stay", outs(), 0);
    frame_to_send("fresh");
    bus.out_ack = 1'b1;
    cyc();
    bus.out_ack = 1'b0;
    check("fresh done", outs(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_decim_ctrl.md
Name: cic_decim_ctrl

Overview:
Control FSM for the CIC decimation path, the receive-side counterpart of the CIC interpolation controller. It accepts fast-rate input samples and pulses the integrator stage once per sample. Every DEC_RATE-th sample it pulses the comb stage and loads the result register. It then presents one slow-rate output sample with a valid/ack handshake. Only control is generated here; the integrator, comb and result registers live in the CIC datapath.

Parameters:
DEC_RATE, 8, decimation ratio R; must be at least 2.
CNT_W, 3, width of the decimation counter; must satisfy 2^CNT_W >= DEC_RATE.

Ports:
CLOCK  input  1  system clock; all state changes on the rising edge.
RESET  input  1  synchronous, active-high reset.
Data_RDY  input  1  fast-rate input sample available, one-cycle pulse.
out_ack  input  1  downstream has taken the output sample.
clr_overrun  input  1  clears the overrun flag.
load_in  output  1  load input sample register.
pulse_integ  output  1  integrator stage enable, one cycle.
pulse_comb  output  1  comb stage enable, one cycle.
load_result  output  1  load decimated result register.
sample_rdy  output  1  output sample valid.
dec_count  output  CNT_W  number of samples integrated in the current frame (0..DEC_RATE-1).
overrun  output  1  sticky flag: an input sample was dropped.

Behaviour:
- Outputs are a Moore decode of the registered state. dec_count and overrun are registers.
- On RESET=1 at a clock edge, regardless of state:
  - state returns to IDLE;
  - dec_count returns to 0 and overrun returns to 0;
  - every output is 0.
- States and transitions:
  - IDLE: all strobes 0. Data_RDY=1 -> LOAD_IN; otherwise stay in IDLE.
  - LOAD_IN: load_in=1, pulse_integ=1. Always -> INTEG_SETTLE.
  - INTEG_SETTLE: no strobes.
    - If dec_count==DEC_RATE-1: dec_count wraps to 0, next state COMB1.
    - Otherwise: dec_count increments, next state IDLE.
  - COMB1: pulse_comb=1, load_result=1. Always -> COMB2.
  - COMB2: no strobes (comb pipeline settle). Always -> SEND.
  - SEND: sample_rdy=1.
    - Held high until out_ack=1 is seen in this state; then -> IDLE.
    - With out_ack=0, stay in SEND indefinitely.
  - Any unused encoding -> IDLE, with all outputs 0.
- Latency, with Data_RDY high in cycle k while in IDLE:
  - load_in and pulse_integ are high in cycle k+1;
  - for the DEC_RATE-th sample, pulse_comb is high in cycle k+3 and sample_rdy first rises in cycle k+5.
- Throughput:
  - Non-final samples need a minimum spacing of 3 cycles.
  - The final sample of a frame needs at least 6 cycles, including the SEND cycle with immediate ack.
- Data_RDY is only accepted in IDLE.
  - Data_RDY=1 in any other state drops the sample: no strobe, no count change, and overrun is set to 1 on the next edge.
  - overrun stays high until clr_overrun=1 or RESET.
  - If clr_overrun and a drop occur in the same cycle, the set wins (overrun=1).
- out_ack is ignored in every state except SEND.
- dec_count never exceeds DEC_RATE-1.
- Reset during SEND discards the pending sample; sample_rdy drops in the cycle after the reset edge.
- All strobes (load_in, pulse_integ, pulse_comb, load_result) are exactly one cycle wide per accepted event.

Test Plan:
1. Reset then idle: RESET=1 for 2 cycles, Data_RDY=0 -> all outputs 0, dec_count=0, and they stay 0 for 20 cycles.
2. Sub-frame samples with DEC_RATE=4: Data_RDY pulses spaced 4 cycles, 3 times -> 3 load_in/pulse_integ pulses, dec_count steps 1,2,3, no pulse_comb, sample_rdy=0.
3. Full frame with DEC_RATE=4: a 4th pulse at cycle k -> pulse_integ at k+1, pulse_comb and load_result at k+3, sample_rdy at k+5, dec_count=0. out_ack at k+5 -> back in IDLE at k+6.
4. Delayed ack: as in 3, but out_ack held low for 7 cycles -> sample_rdy high for 8 consecutive cycles and drops 1 cycle after ack. An out_ack pulse given in IDLE beforehand has no effect.
5. Overrun:
   - Data_RDY pulsed in LOAD_IN and again in SEND -> samples dropped, dec_count unchanged, overrun=1 and sticky.
   - clr_overrun pulse -> overrun=0 next cycle.
   - clr_overrun coinciding with a drop -> overrun stays 1.
6. Reset mid-operation: RESET asserted while in SEND with dec_count=0, and separately in INTEG_SETTLE with dec_count=2 -> next cycle all outputs 0, dec_count=0. The next Data_RDY starts a fresh frame, needing a full 4 samples before pulse_comb.
